// File: rtl/decode_stage.sv
// Decode stage: IF/ID latch, R-type decoder, 32x32 register file with write-back
// bypass, and a registered ID/EX bundle with stall/flush bubble insertion.
`timescale 1ns/1ps
module decode_stage #(
  parameter int unsigned NREG           = 32,
  parameter int unsigned RESET_RF_INDEX = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc4,
  input  logic [31:0] if_inst,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        id_valid,
  output logic [31:0] id_pc4,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_shamt,
  output logic [31:0] id_rs_val,
  output logic [31:0] id_rt_val,
  output logic [2:0]  id_alu_op,
  output logic        id_reg_write,
  output logic        id_illegal
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RIDX_W = 5;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned FN_W   = 6;
  localparam int unsigned ALU_W  = 3;

  localparam logic [FN_W-1:0] FN_ADD = 6'h20;
  localparam logic [FN_W-1:0] FN_SUB = 6'h22;
  localparam logic [FN_W-1:0] FN_AND = 6'h24;
  localparam logic [FN_W-1:0] FN_OR  = 6'h25;
  localparam logic [FN_W-1:0] FN_SLT = 6'h2A;
  localparam logic [FN_W-1:0] FN_SLL = 6'h00;
  localparam logic [FN_W-1:0] FN_SRL = 6'h02;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'd4;
  localparam logic [ALU_W-1:0] ALU_SLL = 3'd5;
  localparam logic [ALU_W-1:0] ALU_SRL = 3'd6;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc4;
    logic [RIDX_W-1:0] rs;
    logic [RIDX_W-1:0] rt;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] shamt;
    logic [XLEN-1:0]   rs_val;
    logic [XLEN-1:0]   rt_val;
    logic [ALU_W-1:0]  alu_op;
    logic              reg_write;
    logic              illegal;
  } idex_t;

  logic            ifid_valid_q;
  logic [XLEN-1:0] ifid_inst_q;
  logic [XLEN-1:0] ifid_pc4_q;

  logic [XLEN-1:0] rf_q [NREG];

  logic [OP_W-1:0]   dec_opcode;
  logic [FN_W-1:0]   dec_funct;
  logic [RIDX_W-1:0] dec_rs;
  logic [RIDX_W-1:0] dec_rt;
  logic [RIDX_W-1:0] dec_rd;
  logic [RIDX_W-1:0] dec_shamt;
  logic [ALU_W-1:0]  dec_alu_op;
  logic              dec_illegal;
  logic              dec_nop;
  logic              dec_reg_write;
  logic [XLEN-1:0]   rs_val;
  logic [XLEN-1:0]   rt_val;

  idex_t idex_d;
  idex_t idex_q;

  // IF/ID latch: flush beats stall; stall holds the current instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= '0;
      ifid_pc4_q   <= '0;
    end else if (flush) begin
      ifid_valid_q <= 1'b0;
      ifid_inst_q  <= '0;
    end else if (!stall) begin
      ifid_valid_q <= if_valid;
      ifid_inst_q  <= if_inst;
      ifid_pc4_q   <= if_pc4;
    end
  end

  assign dec_opcode = ifid_inst_q[31:26];
  assign dec_rs     = ifid_inst_q[25:21];
  assign dec_rt     = ifid_inst_q[20:16];
  assign dec_rd     = ifid_inst_q[15:11];
  assign dec_shamt  = ifid_inst_q[10:6];
  assign dec_funct  = ifid_inst_q[5:0];

  // Only R-type (opcode 0) with a known funct is legal
  always_comb begin
    dec_illegal = 1'b0;
    dec_alu_op  = ALU_ADD;
    if (dec_opcode != '0) begin
      dec_illegal = 1'b1;
    end else begin
      case (dec_funct)
        FN_ADD:  dec_alu_op = ALU_ADD;
        FN_SUB:  dec_alu_op = ALU_SUB;
        FN_AND:  dec_alu_op = ALU_AND;
        FN_OR:   dec_alu_op = ALU_OR;
        FN_SLT:  dec_alu_op = ALU_SLT;
        FN_SLL:  dec_alu_op = ALU_SLL;
        FN_SRL:  dec_alu_op = ALU_SRL;
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // The all-zero word decodes as sll r0,r0,0 but must not write back
  assign dec_nop       = (ifid_inst_q == '0);
  assign dec_reg_write = !dec_illegal && !dec_nop;

  // Register file: r0 is an ordinary register; writes land even under stall/flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf_q[i] <= (RESET_RF_INDEX != 0) ? XLEN'(i) : '0;
      end
    end else if (wb_en) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Same-cycle write-back bypass on each read port
  assign rs_val = (wb_en && (wb_addr == dec_rs)) ? wb_data : rf_q[dec_rs];
  assign rt_val = (wb_en && (wb_addr == dec_rt)) ? wb_data : rf_q[dec_rt];

  always_comb begin
    idex_d = '0;
    if (!stall && !flush && ifid_valid_q) begin
      idex_d.valid     = 1'b1;
      idex_d.pc4       = ifid_pc4_q;
      idex_d.rs        = dec_rs;
      idex_d.rt        = dec_rt;
      idex_d.rd        = dec_rd;
      idex_d.shamt     = dec_shamt;
      idex_d.rs_val    = rs_val;
      idex_d.rt_val    = rt_val;
      idex_d.alu_op    = dec_alu_op;
      idex_d.reg_write = dec_reg_write;
      idex_d.illegal   = dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign id_valid     = idex_q.valid;
  assign id_pc4       = idex_q.pc4;
  assign id_rs        = idex_q.rs;
  assign id_rt        = idex_q.rt;
  assign id_rd        = idex_q.rd;
  assign id_shamt     = idex_q.shamt;
  assign id_rs_val    = idex_q.rs_val;
  assign id_rt_val    = idex_q.rt_val;
  assign id_alu_op    = idex_q.alu_op;
  assign id_reg_write = idex_q.reg_write;
  assign id_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural pipeline model.
`timescale 1ns/1ps
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc4;
  logic [31:0] if_inst;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [31:0] id_pc4;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic [2:0]  id_alu_op;
  logic        id_reg_write;
  logic        id_illegal;

  decode_stage #(.NREG(32), .RESET_RF_INDEX(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_pc4(if_pc4), .if_inst(if_inst),
    .stall(stall), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc4(id_pc4), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_shamt(id_shamt), .id_rs_val(id_rs_val),
    .id_rt_val(id_rt_val), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_illegal(id_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  // Legal functs listed in ALU-code order: index == expected alu_op
  logic [5:0] funct_tbl [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};

  logic [31:0]  m_rf [32];
  logic         m_v;
  logic [31:0]  m_inst;
  logic [31:0]  m_pc4;
  logic [121:0] exp_vec;
  logic [121:0] dut_vec;

  assign dut_vec = {id_valid, id_pc4, id_rs, id_rt, id_rd, id_shamt, id_rs_val,
                    id_rt_val, id_alu_op, id_reg_write, id_illegal};

  function automatic logic [121:0] model_bundle(input logic [31:0] inst,
                                                input logic [31:0] pc4);
    logic [4:0]  rs, rt;
    logic [31:0] rsv, rtv;
    logic [2:0]  alu;
    logic        ill, rw;
    rs  = inst[25:21];
    rt  = inst[20:16];
    ill = 1'b1;
    alu = 3'd0;
    if (inst[31:26] == 6'd0) begin
      for (int i = 0; i < 7; i++) begin
        if (inst[5:0] == funct_tbl[i]) begin
          ill = 1'b0;
          alu = 3'(i);
        end
      end
    end
    rw  = !ill && (inst != 32'd0);
    rsv = (wb_en && wb_addr == rs) ? wb_data : m_rf[rs];
    rtv = (wb_en && wb_addr == rt) ? wb_data : m_rf[rt];
    return {1'b1, pc4, rs, rt, inst[15:11], inst[10:6], rsv, rtv, alu, rw, ill};
  endfunction

  // Behavioural model: one pipeline slot in front of the output bundle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'(i);
      m_v     = 1'b0;
      m_inst  = 32'd0;
      m_pc4   = 32'd0;
      exp_vec = '0;
    end else begin
      exp_vec = (stall || flush || !m_v) ? '0 : model_bundle(m_inst, m_pc4);
      if (wb_en) m_rf[wb_addr] = wb_data;
      if (flush) begin
        m_v    = 1'b0;
        m_inst = 32'd0;
      end else if (!stall) begin
        m_v    = if_valid;
        m_inst = if_inst;
        m_pc4  = if_pc4;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (dut_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL idex_bundle t=%0t got=%h expected=%h", $time, dut_vec, exp_vec);
      end
    end
  end

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    if_valid = v;
    if_pc4   = pc;
    if_inst  = inst;
  endtask

  function automatic logic [31:0] rand_inst();
    int unsigned k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'd0;
    if (k == 1) return $urandom();
    if (k == 2) return {6'($urandom_range(1, 63)), 26'($urandom())};
    if (k == 3) return {6'd0, 20'($urandom()), 6'($urandom())};
    return {6'd0, 20'($urandom()), funct_tbl[$urandom_range(0, 6)]};
  endfunction

  initial begin
    logic [31:0] tmp;
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    stall = 1'b0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    tick();
    tick();
    pin("reset_valid", 32'(id_valid), 32'd0);
    pin("reset_bundle_zero", 32'(dut_vec != '0), 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // add r0,r1,r2: two-edge latency, then a bubble
    drive(1'b1, 32'h10, 32'h0022_0020);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    tick();
    pin("add_valid", 32'(id_valid), 32'd1);
    pin("add_rs", 32'(id_rs), 32'd1);
    pin("add_rt", 32'(id_rt), 32'd2);
    pin("add_rd", 32'(id_rd), 32'd0);
    pin("add_rs_val", id_rs_val, 32'd1);
    pin("add_rt_val", id_rt_val, 32'd2);
    pin("add_alu_op", 32'(id_alu_op), 32'd0);
    pin("add_reg_write", 32'(id_reg_write), 32'd1);
    tick();
    pin("add_then_bubble", 32'(id_valid), 32'd0);

    // Back-to-back stream, pc4 = 1..5
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 32'(i), 32'h0022_0020);
      tick();
      if (i >= 2) begin
        pin("stream_valid", 32'(id_valid), 32'd1);
        pin("stream_pc4", id_pc4, 32'(i - 1));
      end
    end
    drive(1'b0, 32'd0, 32'd0);
    tick();
    pin("stream_last_pc4", id_pc4, 32'd5);

    // add r3,r4,r5 with same-cycle write to r4
    drive(1'b1, 32'h20, 32'h0085_1820);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'hDEAD_BEEF;
    tick();
    pin("bypass_rs_val", id_rs_val, 32'hDEAD_BEEF);
    pin("bypass_rt_val", id_rt_val, 32'd5);
    wb_en = 1'b0;
    drive(1'b1, 32'h21, 32'h0085_1820);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    tick();
    pin("rf4_written", id_rs_val, 32'hDEAD_BEEF);

    // Two-cycle stall on add r6,r7,r8 with a write to r7 during the stall
    drive(1'b1, 32'h40, 32'h00E8_3020);
    tick();
    stall = 1'b1;
    drive(1'b1, 32'h99, 32'h0000_0022);
    tick();
    pin("stall_bubble1_valid", 32'(id_valid), 32'd0);
    pin("stall_bubble1_rw", 32'(id_reg_write), 32'd0);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    tick();
    pin("stall_bubble2_valid", 32'(id_valid), 32'd0);
    wb_en = 1'b0;
    stall = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    tick();
    pin("stall_release_valid", 32'(id_valid), 32'd1);
    pin("stall_release_pc4", id_pc4, 32'h40);
    pin("stall_release_rs_val", id_rs_val, 32'h77);
    pin("stall_release_rt_val", id_rt_val, 32'd8);
    tick();
    pin("stall_word_dropped", 32'(id_valid), 32'd0);

    // flush with stall: instruction lost
    drive(1'b1, 32'h50, 32'h0022_0020);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    flush = 1'b1; stall = 1'b1;
    tick();
    pin("flush_bubble", 32'(id_valid), 32'd0);
    flush = 1'b0; stall = 1'b0;
    tick();
    pin("flush_lost", 32'(id_valid), 32'd0);

    // Illegal opcode and illegal funct
    drive(1'b1, 32'h60, 32'h8C22_0000);
    tick();
    drive(1'b1, 32'h61, 32'h0000_003F);
    tick();
    pin("ill_op_valid", 32'(id_valid), 32'd1);
    pin("ill_op_illegal", 32'(id_illegal), 32'd1);
    pin("ill_op_rw", 32'(id_reg_write), 32'd0);
    drive(1'b0, 32'd0, 32'd0);
    tick();
    pin("ill_fn_illegal", 32'(id_illegal), 32'd1);
    pin("ill_fn_rw", 32'(id_reg_write), 32'd0);

    // NOP word
    drive(1'b1, 32'h70, 32'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    tick();
    pin("nop_valid", 32'(id_valid), 32'd1);
    pin("nop_alu_op", 32'(id_alu_op), 32'd5);
    pin("nop_rw", 32'(id_reg_write), 32'd0);

    // Randomized traffic, writes biased toward the registers being read
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 3) != 0, $urandom(), rand_inst());
      stall = ($urandom_range(0, 6) == 0);
      flush = ($urandom_range(0, 11) == 0);
      wb_en = 1'($urandom_range(0, 1));
      tmp   = m_inst;
      case ($urandom_range(0, 2))
        0:       wb_addr = tmp[25:21];
        1:       wb_addr = tmp[20:16];
        default: wb_addr = 5'($urandom());
      endcase
      wb_data = $urandom();
      tick();
    end

    // Asynchronous reset mid-stream
    drive(1'b1, 32'h80, 32'h0022_0020);
    stall = 1'b0; flush = 1'b0; wb_en = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    pin("async_rst_valid", 32'(id_valid), 32'd0);
    pin("async_rst_bundle_zero", 32'(dut_vec != '0), 32'd0);
    drive(1'b0, 32'd0, 32'd0);
    tick();
    rst_n = 1'b1;
    drive(1'b1, 32'h90, 32'h012A_0820);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    tick();
    pin("post_rst_rs_val", id_rs_val, 32'd9);
    pin("post_rst_rt_val", id_rt_val, 32'd10);
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage directly downstream of the fetch stage. Consumes the fetch outputs (PC+1, instruction word) and registers them in an IF/ID latch.
- Decodes R-type instructions and reads a 32x32 register file, which has a write-back port and same-cycle bypass.
- Drives a registered ID/EX bundle to the execute stage. Supports stall (bubble insertion) and flush.

Parameters:
- NREG, 32, number of architectural registers (address width is 5 bits, fixed)
- RESET_RF_INDEX, 1, 1: reset loads rf[i]=i (bench-friendly); 0: reset clears rf[i]=0

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- if_valid  input  1  fetch output is a real instruction this cycle
- if_pc4  input  32  word-indexed PC+1 from fetch
- if_inst  input  32  instruction word from fetch
- stall  input  1  hold IF/ID, insert bubble into ID/EX
- flush  input  1  squash IF/ID contents
- wb_en  input  1  register-file write enable
- wb_addr  input  5  write-back register index
- wb_data  input  32  write-back data
- id_valid  output  1  ID/EX bundle holds a real instruction
- id_pc4  output  32  PC+1 carried forward
- id_rs  output  5  source register index rs (bits 25:21)
- id_rt  output  5  source register index rt (bits 20:16)
- id_rd  output  5  destination register index rd (bits 15:11)
- id_shamt  output  5  shift amount (bits 10:6)
- id_rs_val  output  32  operand A
- id_rt_val  output  32  operand B
- id_alu_op  output  3  ALU operation code
- id_reg_write  output  1  execute/writeback must write rd
- id_illegal  output  1  instruction not supported

Behaviour:
- Reset (async, rst_n=0): IF/ID valid=0, IF/ID inst=0, IF/ID pc4=0. All id_* outputs =0. Register file rf[i]=i if RESET_RF_INDEX=1, else 0. Reset deasserted mid-stream: the first capture occurs at the next clk edge.
- IF/ID latch, per edge, in priority order:
  - flush: valid<=0, inst<=0.
  - else stall: hold.
  - else: valid<=if_valid, inst<=if_inst, pc4<=if_pc4.
- ID/EX register, per edge:
  - If stall, flush, or IF/ID invalid: bubble. id_valid=0, id_reg_write=0, id_illegal=0, all data fields=0.
  - Else: load the decoded IF/ID contents.
- Latency: an instruction presented with if_valid at edge N is visible on the id_* outputs after edge N+1, i.e. 2 edges.
- Decode: opcode=inst[31:26], funct=inst[5:0].
  - opcode!=0: id_illegal=1, id_reg_write=0.
  - funct mapping: 0x20 add->0, 0x22 sub->1, 0x24 and->2, 0x25 or->3, 0x2A slt->4, 0x00 sll->5, 0x02 srl->6. Any other funct: illegal.
  - All-zero word is a NOP: id_valid=1, id_reg_write=0, id_alu_op=5, not illegal.
  - Legal, non-NOP: id_reg_write=1.
  - illegal forces id_reg_write=0; id_valid stays 1 so execute can trap.
- Register file:
  - Two combinational read ports (rs, rt) indexed from the IF/ID instruction, plus one synchronous write port.
  - Register 0 is writable; there is no hardwired zero.
  - Write occurs on an edge with wb_en=1 and takes effect even during stall/flush.
- Bypass: if wb_en=1 and wb_addr matches rs (or rt) in the same cycle as the read, the operand uses wb_data instead of the stale rf value. Both operands may bypass simultaneously.
- Stall with an instruction held in IF/ID: re-decoded every cycle; register values are re-read, so writes completed during the stall are observed on release.
- flush and stall both high: flush wins.
- No wrap-around or arithmetic in this block; pc4 passes through unmodified.

Test Plan:
- Reset, RESET_RF_INDEX=1; present 0x00221020-style word 0x00220020 (add 0,1,2), if_valid=1 for one cycle -> after 2 edges: id_valid=1, id_rs=1, id_rt=2, id_rd=0, id_rs_val=1, id_rt_val=2, id_alu_op=0, id_reg_write=1. Next cycle id_valid=0.
- Stream 5 instructions back-to-back with pc4=1..5 -> five consecutive valid ID/EX bundles, id_pc4=1..5, no gaps.
- With add 3,4,5 (0x00851820) in IF/ID, drive wb_en=1, wb_addr=4, wb_data=0xDEADBEEF same cycle -> id_rs_val=0xDEADBEEF, id_rt_val=5. On a subsequent read, rf[4]=0xDEADBEEF.
- Assert stall 2 cycles while add 6,7,8 sits in IF/ID -> two bubbles (id_valid=0, id_reg_write=0). The instruction then emerges once with correct operands; the fetch word presented during the stall is not captured.
- Assert flush with stall also high -> IF/ID invalidated; next bundle is a bubble; the instruction is lost.
- Present opcode 0x23 word 0x8C220000 -> id_valid=1, id_illegal=1, id_reg_write=0. funct 0x3F with opcode 0 -> illegal.
- Pull rst_n low mid-stream -> all id_* outputs 0 immediately (asynchronous); rf returns to rf[i]=i.
